// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  localparam logic [WORD_W-1:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD,
    COMMIT,
    DONE
  } state_e;

endpackage

// File: rtl/loader_idle_timer.sv
// Idle-cycle counter between bytes of a partial word; expire_c_o is combinational.
module loader_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last_c;

  assign at_last_c  = (cnt_q == LAST);
  assign expire_c_o = en_i && !clear_i && at_last_c;

  // Clear dominates; the counter folds back to zero on expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Packs UART bytes into little-endian words, writes them to instruction memory
// from address 0, and holds the core in reset until the terminator or full memory.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [WORD_W-1:0] END_WORD    = END_WORD_DEFAULT,
  parameter int unsigned       TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              core_rst,
  output logic              write_done,
  output logic              overflow,
  output logic              timeout_err
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                core_rst_q, core_rst_d;
  logic                write_done_q, write_done_d;
  logic                overflow_q, overflow_d;
  logic                timeout_err_q, timeout_err_d;

  logic                timer_en_c, timer_clear_c, expire_c;
  logic [IDX_W+2:0]    bit_lo_c;

  assign bit_lo_c      = {byte_idx_q, 3'b000};
  assign timer_en_c    = (state_q == LOAD) && (byte_idx_q != '0);
  assign timer_clear_c = rx_valid || rx_break || !timer_en_c;

  loader_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear_c),
    .en_i       (timer_en_c),
    .expire_c_o (expire_c)
  );

  // The write strobe is raised on the edge entering COMMIT so it is visible
  // in the COMMIT cycle itself; COMMIT then advances the address.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    word_count_d  = word_count_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    overflow_d    = overflow_q;
    timeout_err_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (rx_break) begin
          byte_idx_d = '0;
        end else if (rx_valid) begin
          word_d[bit_lo_c +: BYTE_W] = rx_data;
          if (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
            byte_idx_d = '0;
            state_d    = COMMIT;
            if (word_d != END_WORD) begin
              wr_en_d   = 1'b1;
              wr_addr_d = word_count_q[ADDR_W-1:0];
              wr_data_d = word_d;
            end
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else if (expire_c) begin
          byte_idx_d    = '0;
          word_d        = '0;
          timeout_err_d = 1'b1;
        end
      end

      COMMIT: begin
        // A byte arriving here starts the next word (byte_idx is already 0).
        if (rx_valid && !rx_break) begin
          word_d[BYTE_W-1:0] = rx_data;
          byte_idx_d         = IDX_W'(1);
        end
        if (word_q == END_WORD) begin
          state_d = DONE;
        end else begin
          word_count_d = word_count_q + (ADDR_W+1)'(1);
          if (word_count_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
            state_d    = DONE;
            overflow_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    core_rst_d   = (state_d != DONE);
    write_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      byte_idx_q    <= '0;
      word_q        <= '0;
      word_count_q  <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      core_rst_q    <= 1'b1;
      write_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      word_count_q  <= word_count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      core_rst_q    <= core_rst_d;
      write_done_q  <= write_done_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign word_count   = word_count_q;
  assign core_rst     = core_rst_q;
  assign write_done   = write_done_q;
  assign overflow     = overflow_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: directed scenarios plus random byte streams
// checked against a byte-list model of the loading rules.
module tb_uart_imem_loader;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 100;

  localparam int EV_BYTE = 0;
  localparam int EV_BRKB = 1;
  localparam int EV_BRK  = 2;
  localparam int EV_IDLE = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  logic [ADDR_W:0]   word_count;
  logic              core_rst;
  logic              write_done;
  logic              overflow;
  logic              timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Writes and pulses observed on the falling edge.
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  int                to_seen;
  bit                core_rst_low_seen;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         n;
  } ev_t;
  ev_t evq[$];

  // Model results
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  int                exp_to;
  int                exp_count;
  bit                exp_done;
  bit                exp_ovf;

  uart_imem_loader #(
    .ADDR_W      (ADDR_W),
    .END_WORD    (32'hFFFF_FFFF),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .word_count   (word_count),
    .core_rst     (core_rst),
    .write_done   (write_done),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      got_addr.push_back(imem_wr_addr);
      got_data.push_back(imem_wr_data);
    end
    if (timeout_err === 1'b1) to_seen++;
    if (core_rst !== 1'b1) core_rst_low_seen = 1'b1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
    tick();
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
    to_seen           = 0;
    core_rst_low_seen = 1'b0;
  endtask

  // Reference: bytes collect into a list; 4 bytes make a word.
  task automatic run_model();
    logic [7:0]  part[$];
    logic [31:0] w;
    int          idle_run;
    exp_addr.delete();
    exp_data.delete();
    exp_to = 0; exp_count = 0; exp_done = 0; exp_ovf = 0;
    idle_run = 0;
    foreach (evq[i]) begin
      if (exp_done) continue;
      if (evq[i].kind == EV_BYTE) begin
        part.push_back(evq[i].b);
        idle_run = 0;
        if (part.size() == 4) begin
          w = {part[3], part[2], part[1], part[0]};
          part.delete();
          if (w == 32'hFFFF_FFFF) begin
            exp_done = 1;
          end else begin
            exp_addr.push_back(ADDR_W'(exp_count));
            exp_data.push_back(w);
            exp_count++;
            if (exp_count == DEPTH) begin
              exp_done = 1;
              exp_ovf  = 1;
            end
          end
        end
      end else if (evq[i].kind == EV_IDLE) begin
        if (part.size() > 0) begin
          if (idle_run + evq[i].n >= TIMEOUT) begin
            exp_to++;
            part.delete();
            idle_run = 0;
          end else begin
            idle_run += evq[i].n;
          end
        end
      end else begin
        part.delete();
        idle_run = 0;
      end
    end
  endtask

  task automatic play_events();
    foreach (evq[i]) begin
      case (evq[i].kind)
        EV_BYTE: send_byte(evq[i].b);
        EV_BRKB: begin rx_break = 1'b1; send_byte(evq[i].b); rx_break = 1'b0; end
        EV_BRK:  begin rx_break = 1'b1; tick(); rx_break = 1'b0; end
        default: idle(evq[i].n);
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_break = 1'b0;
    send_byte(8'h5A);
    do_reset();
    n_cmp++; if (imem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", imem_wr_en); end
    n_cmp++; if (imem_wr_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_wr_addr); end
    n_cmp++; if (imem_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", imem_wr_data); end
    n_cmp++; if (word_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", word_count); end
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    n_cmp++; if ({write_done, overflow, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {write_done, overflow, timeout_err}); end
  endtask

  task automatic test_basic_word();
    do_reset();
    send_word(32'hFC01_0113);
    n_cmp++; if (imem_wr_en !== 1'b1) begin n_fail++; $display("FAIL basic_wr_en: got %b expected 1", imem_wr_en); end
    n_cmp++; if (imem_wr_addr !== 2'd0) begin n_fail++; $display("FAIL basic_addr: got %h expected 0", imem_wr_addr); end
    n_cmp++; if (imem_wr_data !== 32'hFC01_0113) begin n_fail++; $display("FAIL basic_data: got %h expected fc010113", imem_wr_data); end
    tick();
    n_cmp++; if (imem_wr_en !== 1'b0) begin n_fail++; $display("FAIL basic_single_strobe: got %b expected 0", imem_wr_en); end
    n_cmp++; if (word_count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", word_count); end
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL basic_core_rst: got %b expected 1", core_rst); end
  endtask

  task automatic test_terminator();
    do_reset();
    send_word(32'h0000_0000);
    send_word(32'hFC01_0113);
    send_word(32'h0281_2E23);
    send_word(32'hFFFF_FFFF);
    n_cmp++; if (imem_wr_en !== 1'b0) begin n_fail++; $display("FAIL term_no_write: got %b expected 0", imem_wr_en); end
    tick();
    n_cmp++; if (write_done !== 1'b1) begin n_fail++; $display("FAIL term_done: got %b expected 1", write_done); end
    n_cmp++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL term_core_rst: got %b expected 0", core_rst); end
    send_word(32'h0403_0201);
    idle(3);
    n_cmp++; if (got_addr.size() !== 3) begin n_fail++; $display("FAIL term_nwrites: got %0d expected 3", got_addr.size()); end
    for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
      n_cmp++; if (got_addr[i] !== ADDR_W'(i)) begin n_fail++; $display("FAIL term_addr%0d: got %h expected %h", i, got_addr[i], i); end
    end
    if (got_data.size() >= 3) begin
      n_cmp++; if (got_data[1] !== 32'hFC01_0113) begin n_fail++; $display("FAIL term_data1: got %h expected fc010113", got_data[1]); end
    end
    n_cmp++; if (imem_wr_data !== 32'h0281_2E23) begin n_fail++; $display("FAIL term_data_hold: got %h expected 02812e23", imem_wr_data); end
    n_cmp++; if (word_count !== 3'd3 || overflow !== 1'b0) begin n_fail++; $display("FAIL term_count_ovf: got %0d/%b expected 3/0", word_count, overflow); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TIMEOUT);
    send_word(32'hFC01_0113);
    idle(2);
    n_cmp++; if (to_seen !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", to_seen); end
    n_cmp++; if (got_data.size() !== 1 || got_data[0] !== 32'hFC01_0113) begin n_fail++; $display("FAIL timeout_word: got %0d writes, last %h expected 1 of fc010113", got_data.size(), imem_wr_data); end
    // Expiry coinciding with a byte: the byte wins
    send_byte(8'h55);
    idle(TIMEOUT - 1);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    idle(2);
    n_cmp++; if (to_seen !== 1) begin n_fail++; $display("FAIL timeout_coincide: got %0d pulses expected 1", to_seen); end
    n_cmp++; if (imem_wr_data !== 32'h8877_6655 || imem_wr_addr !== 2'd1) begin n_fail++; $display("FAIL timeout_coincide_word: got %h@%h expected 88776655@1", imem_wr_data, imem_wr_addr); end
  endtask

  task automatic test_break();
    do_reset();
    send_byte(8'h11);
    rx_break = 1'b1; send_byte(8'h22); rx_break = 1'b0;
    send_word(32'h0010_0793);
    idle(3);
    n_cmp++; if (got_data.size() !== 1) begin n_fail++; $display("FAIL break_nwrites: got %0d expected 1", got_data.size()); end
    n_cmp++; if (imem_wr_data !== 32'h0010_0793) begin n_fail++; $display("FAIL break_data: got %h expected 00100793", imem_wr_data); end
    n_cmp++; if (to_seen !== 0) begin n_fail++; $display("FAIL break_no_err: got %0d expected 0", to_seen); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'h0000_0013 + 32'(i) * 32'h100);
    idle(3);
    n_cmp++; if (got_addr.size() !== DEPTH) begin n_fail++; $display("FAIL ovf_nwrites: got %0d expected 4", got_addr.size()); end
    for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== 32'h0000_0013 + 32'(i) * 32'h100 || got_addr[i] !== ADDR_W'(i)) begin n_fail++; $display("FAIL ovf_write%0d: got %h@%h expected %h@%h", i, got_data[i], got_addr[i], 32'h13 + 32'(i) * 32'h100, i); end
    end
    n_cmp++; if ({overflow, write_done, core_rst} !== 3'b110) begin n_fail++; $display("FAIL ovf_flags: got %b expected 110", {overflow, write_done, core_rst}); end
    n_cmp++; if (word_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", word_count); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b1; tick(); rst = 1'b0;
    send_word(32'hFFE0_0793);
    idle(2);
    n_cmp++; if (got_data.size() !== 1 || imem_wr_data !== 32'hFFE0_0793 || imem_wr_addr !== 2'd0) begin n_fail++; $display("FAIL midrst_write: got %0d writes %h@%h expected 1 ffe00793@0", got_data.size(), imem_wr_data, imem_wr_addr); end
    n_cmp++; if (core_rst_low_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_core_rst: got low pulse expected held high"); end
  endtask

  task automatic test_random_streams();
    int gap, r;
    for (int it = 0; it < 8; it++) begin
      evq.delete();
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
        for (int k = 0; k < 4; k++) begin
          r = int'($urandom_range(0, 99));
          if (r < 3) evq.push_back('{EV_BRK, 8'h00, 0});
          else if (r < 6) evq.push_back('{EV_BRKB, 8'($urandom_range(0, 255)), 0});
          r = int'($urandom_range(0, 19));
          if (r == 0) gap = int'($urandom_range(TIMEOUT, TIMEOUT + 10));
          else if (r == 1) gap = TIMEOUT - 1;
          else if (r < 12) gap = 0;
          else gap = int'($urandom_range(1, 5));
          if (gap > 0) evq.push_back('{EV_IDLE, 8'h00, gap});
          evq.push_back('{EV_BYTE, 8'($urandom_range(0, 255)), 0});
        end
      end
      if ($urandom_range(0, 1) == 1) for (int k = 0; k < 4; k++) evq.push_back('{EV_BYTE, 8'hFF, 0});
      run_model();
      do_reset();
      play_events();
      idle(3);
      n_cmp++; if (got_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", it, got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_cmp++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL rand%0d_write%0d: got %h@%h expected %h@%h", it, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]); end
      end
      n_cmp++; if (to_seen !== exp_to) begin n_fail++; $display("FAIL rand%0d_timeouts: got %0d expected %0d", it, to_seen, exp_to); end
      n_cmp++; if (word_count !== (ADDR_W+1)'(exp_count)) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, word_count, exp_count); end
      n_cmp++; if ({write_done, overflow, core_rst} !== {exp_done, exp_ovf, !exp_done}) begin n_fail++; $display("FAIL rand%0d_flags: got %b expected %b", it, {write_done, overflow, core_rst}, {exp_done, exp_ovf, !exp_done}); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic_word();
    test_terminator();
    test_timeout();
    test_break();
    test_overflow();
    test_reset_mid_word();
    test_random_streams();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
